// File: rtl/axil_mem_pkg.sv
// Shared response encoding and error-counter helper for the AXI-Lite style memory core.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package axil_mem_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Add 0..2 error events to an 8-bit counter, sticking at the maximum.
    function automatic logic [7:0] err_sat_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'b0, inc};
        return sum[8] ? ERR_CNT_MAX : sum[7:0];
    endfunction

endpackage

// File: rtl/axil_mem_rdpipe.sv
// Read response delay line: valid, response and data travel READ_LATENCY register stages.
// Latency: exactly READ_LATENCY cycles from in_vld to out_vld; one entry accepted per cycle.
// Backpressure: none; the consumer must take every out_vld pulse. Data stages load only on valid, so outputs hold.
module axil_mem_rdpipe
    import axil_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_vld,
    input  resp_t                 in_resp,
    input  logic [DATA_WIDTH-1:0] in_dat,
    output logic                  out_vld,
    output resp_t                 out_resp,
    output logic [DATA_WIDTH-1:0] out_dat
);

    logic [READ_LATENCY-1:0] vld_q;
    resp_t                   resp_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   dat_q  [READ_LATENCY];

    // Shift valid every cycle; payload stages only load when a valid entry arrives so the last stage holds between pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                resp_q[i] <= RESP_DECERR;
                dat_q[i]  <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            if (in_vld) begin
                resp_q[0] <= in_resp;
                dat_q[0]  <= in_dat;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    resp_q[i] <= resp_q[i-1];
                    dat_q[i]  <= dat_q[i-1];
                end
            end
        end
    end

    assign out_vld  = vld_q[READ_LATENCY-1];
    assign out_resp = resp_q[READ_LATENCY-1];
    assign out_dat  = dat_q[READ_LATENCY-1];

endmodule

// File: rtl/axil_mem_core.sv
// Word-addressed memory with byte-strobed writes, a read-only constant low region and error counting.
// Latency: write response 1 cycle after WEN; read response READ_LATENCY cycles after REN, fully pipelined.
// Backpressure: none; one write and one read accepted every cycle, responses are unconditional pulses.
module axil_mem_core
    import axil_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DATA_DEPTH   = 64,
    parameter int ADDR_WIDTH   = 8,
    parameter int RO_LIMIT     = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    WEN,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    output logic [1:0]              WRESP,
    output logic                    WDONE,
    input  logic                    REN,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RDONE,
    output logic [7:0]              ERR_CNT
);

    localparam int          IDX_W   = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int          NBYTES  = DATA_WIDTH / 8;
    localparam logic [31:0] DEPTH_U = 32'(DATA_DEPTH);
    localparam logic [31:0] RO_U    = 32'(RO_LIMIT);

    // Array has no reset. The read-only words are never stored here: their
    // power-up constants are produced by the read mux, so no write or reset can touch them.
    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    resp_t                 wr_resp_nxt;
    resp_t                 rd_resp_in;
    logic [DATA_WIDTH-1:0] rd_dat_in;
    logic [31:0]           ro_val;
    logic                  wr_ok;
    logic                  wr_err;
    logic                  rd_err;
    logic [1:0]            err_inc;
    logic                  rd_vld;
    resp_t                 rd_resp;
    logic [DATA_WIDTH-1:0] rd_dat;

    // Decode both requests; the read samples the array before this cycle's write lands (read-first).
    always_comb begin
        wr_idx      = AWADDR[IDX_W-1:0];
        rd_idx      = ARADDR[IDX_W-1:0];
        wr_resp_nxt = RESP_OKAY;
        rd_resp_in  = RESP_OKAY;
        rd_dat_in   = '0;
        ro_val      = RO_U - 32'(ARADDR);
        if (32'(AWADDR) >= DEPTH_U) begin
            wr_resp_nxt = RESP_DECERR;
        end else if (32'(AWADDR) < RO_U) begin
            wr_resp_nxt = RESP_SLVERR;
        end
        if (32'(ARADDR) >= DEPTH_U) begin
            rd_resp_in = RESP_DECERR;
        end else if (32'(ARADDR) < RO_U) begin
            rd_dat_in = DATA_WIDTH'(ro_val);
        end else begin
            rd_dat_in = mem[rd_idx];
        end
        wr_ok = WEN && (wr_resp_nxt == RESP_OKAY);
    end

    // Byte-lane write into the array; rejected writes never reach it.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (WSTRB[b]) begin
                    mem[wr_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
                end
            end
        end
    end

    // Write response: one-cycle done pulse, response held until the next write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            WDONE <= 1'b0;
            WRESP <= RESP_DECERR;
        end else begin
            WDONE <= WEN;
            if (WEN) begin
                WRESP <= wr_resp_nxt;
            end
        end
    end

    axil_mem_rdpipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rdpipe (
        .clk      (clk),
        .resetn   (resetn),
        .in_vld   (REN),
        .in_resp  (rd_resp_in),
        .in_dat   (rd_dat_in),
        .out_vld  (rd_vld),
        .out_resp (rd_resp),
        .out_dat  (rd_dat)
    );

    assign RDONE = rd_vld;
    assign RRESP = rd_resp;
    assign RDATA = rd_dat;

    // Count error responses as they are emitted on the output pulses.
    always_comb begin
        wr_err  = WDONE && (WRESP != RESP_OKAY);
        rd_err  = RDONE && (RRESP != RESP_OKAY);
        err_inc = {1'b0, wr_err} + {1'b0, rd_err};
    end

    // Saturating error counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ERR_CNT <= '0;
        end else begin
            ERR_CNT <= err_sat_add(ERR_CNT, err_inc);
        end
    end

endmodule

// File: tb/tb_axil_mem_core.sv
// Scoreboard bench for axil_mem_core: expected responses queued at drive time, popped on WDONE/RDONE.
// Latency: checks response cycle against issue cycle (write +1, read +READ_LATENCY).
// Backpressure: n/a; the DUT never stalls.
module tb_axil_mem_core;

    localparam int L = 2;

    typedef struct {
        logic [31:0] dat;
        logic [1:0]  resp;
        int          due;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        WEN;
    logic [7:0]  AWADDR;
    logic [3:0]  WSTRB;
    logic [31:0] WDATA;
    logic [1:0]  WRESP;
    logic        WDONE;
    logic        REN;
    logic [7:0]  ARADDR;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RDONE;
    logic [7:0]  ERR_CNT;

    exp_t        rdq[$];
    exp_t        wrq[$];
    exp_t        mon_r;
    exp_t        mon_w;
    logic [31:0] mm [64];
    int          cyc = 0;
    int          rd_seen = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int          seen0;

    axil_mem_core #(
        .DATA_WIDTH   (32),
        .DATA_DEPTH   (64),
        .ADDR_WIDTH   (8),
        .RO_LIMIT     (10),
        .READ_LATENCY (L)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .WEN     (WEN),
        .AWADDR  (AWADDR),
        .WSTRB   (WSTRB),
        .WDATA   (WDATA),
        .WRESP   (WRESP),
        .WDONE   (WDONE),
        .REN     (REN),
        .ARADDR  (ARADDR),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RDONE   (RDONE),
        .ERR_CNT (ERR_CNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time-stamp issue and completion.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare every response pulse against the head of its queue.
    always @(negedge clk) begin
        if (RDONE === 1'b1) begin
            rd_seen++;
            if (rdq.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                mon_r = rdq.pop_front();
                chk("rdata", RDATA, mon_r.dat);
                chk("rresp", RRESP, mon_r.resp);
                chk("rd_cycle", cyc, mon_r.due);
            end
        end
        if (WDONE === 1'b1) begin
            if (wrq.size() == 0) begin
                chk("wr_unexpected", 1, 0);
            end else begin
                mon_w = wrq.pop_front();
                chk("wresp", WRESP, mon_w.resp);
                chk("wr_cycle", cyc, mon_w.due);
            end
        end
    end

    // Drive one cycle of requests (called at a negedge) and queue the expected responses.
    task automatic drive(input logic wen, input logic [7:0] wa, input logic [3:0] ws,
                         input logic [31:0] wd, input logic ren, input logic [7:0] ra);
        exp_t e;
        WEN = wen; AWADDR = wa; WSTRB = ws; WDATA = wd;
        REN = ren; ARADDR = ra;
        if (ren) begin
            e.due = cyc + L;
            if (ra >= 8'd64) begin
                e.dat = '0; e.resp = 2'b11;
            end else if (ra < 8'd10) begin
                e.dat = 32'(10 - int'(ra)); e.resp = 2'b00;
            end else begin
                e.dat = mm[ra[5:0]]; e.resp = 2'b00;
            end
            rdq.push_back(e);
        end
        if (wen) begin
            e.due = cyc + 1;
            e.dat = '0;
            if (wa >= 8'd64) begin
                e.resp = 2'b11;
            end else if (wa < 8'd10) begin
                e.resp = 2'b10;
            end else begin
                e.resp = 2'b00;
                for (int b = 0; b < 4; b++)
                    if (ws[b]) mm[wa[5:0]][b*8 +: 8] = wd[b*8 +: 8];
            end
            wrq.push_back(e);
        end
        @(negedge clk);
        WEN = 1'b0;
        REN = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for all outstanding responses.
    task automatic drain();
        for (int i = 0; i < 20 && (rdq.size() != 0 || wrq.size() != 0); i++)
            @(negedge clk);
        chk("drain_rd", rdq.size(), 0);
        chk("drain_wr", wrq.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 10; i++) mm[i] = 32'(10 - i);
        resetn = 1'b0; WEN = 1'b0; REN = 1'b0;
        AWADDR = '0; ARADDR = '0; WSTRB = '0; WDATA = '0;
        repeat (3) @(negedge clk);
        chk("rst_wdone", WDONE, 0);
        chk("rst_rdone", RDONE, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_wresp", WRESP, 2'b11);
        chk("rst_rresp", RRESP, 2'b11);
        chk("rst_errcnt", ERR_CNT, 0);

        // First request lands on the first rising edge after release.
        resetn = 1'b1;
        drive(1, 8'd20, 4'hF, 32'h0, 0, 8'd0);
        drive(1, 8'd20, 4'b0101, 32'hDEADBEEF, 0, 8'd0);
        drive(0, 8'd0, 4'h0, 32'h0, 1, 8'd20);
        // Read-only and out-of-range writes.
        drive(1, 8'd3, 4'hF, 32'h55555555, 0, 8'd0);
        drive(1, 8'd70, 4'hF, 32'h66666666, 0, 8'd0);
        drive(0, 8'd0, 4'h0, 32'h0, 1, 8'd3);
        drain();
        idle(2);
        chk("errcnt_two", ERR_CNT, 2);

        // Back-to-back reads of the constant region.
        for (int a = 0; a < 4; a++) drive(0, 8'd0, 4'h0, 32'h0, 1, 8'(a));
        drain();

        // Same-cycle read/write returns old data, next read returns new.
        drive(1, 8'd30, 4'hF, 32'h11, 0, 8'd0);
        drive(1, 8'd30, 4'hF, 32'h22, 1, 8'd30);
        drive(0, 8'd0, 4'h0, 32'h0, 1, 8'd30);

        // Zero strobe is OKAY and changes nothing; DECERR read.
        drive(1, 8'd40, 4'hF, 32'h12345678, 0, 8'd0);
        drive(1, 8'd40, 4'h0, 32'hFFFFFFFF, 0, 8'd0);
        drive(0, 8'd0, 4'h0, 32'h0, 1, 8'd100);
        drive(0, 8'd0, 4'h0, 32'h0, 1, 8'd40);
        drain();
        idle(2);
        chk("errcnt_three", ERR_CNT, 3);

        // Reset with two reads in flight.
        drive(0, 8'd0, 4'h0, 32'h0, 1, 8'd20);
        drive(0, 8'd0, 4'h0, 32'h0, 1, 8'd20);
        #2;
        resetn = 1'b0;
        rdq.delete();
        #1;
        chk("arst_rdone", RDONE, 0);
        chk("arst_rdata", RDATA, 0);
        chk("arst_rresp", RRESP, 2'b11);
        chk("arst_wresp", WRESP, 2'b11);
        chk("arst_errcnt", ERR_CNT, 0);
        idle(2);
        resetn = 1'b1;
        seen0 = rd_seen;
        idle(6);
        chk("flush_no_rdone", rd_seen, seen0);
        chk("post_rst_rdata", RDATA, 0);
        chk("post_rst_rresp", RRESP, 2'b11);
        chk("post_rst_errcnt", ERR_CNT, 0);
        drive(0, 8'd0, 4'h0, 32'h0, 1, 8'd20);
        drain();

        // Saturation of the error counter.
        for (int i = 0; i < 254; i++) drive(0, 8'd0, 4'h0, 32'h0, 1, 8'd200);
        drain();
        idle(2);
        chk("errcnt_254", ERR_CNT, 254);
        for (int i = 0; i < 46; i++) drive(0, 8'd0, 4'h0, 32'h0, 1, 8'd200);
        drain();
        idle(2);
        chk("errcnt_sat", ERR_CNT, 255);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/axil_mem_core.md
AXIL_MEM_CORE -- requirements
Module: axil_mem_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (multiple of 8, 8..128).
REQ-002 SHALL have parameter DATA_DEPTH, default 64, number of words.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, word-address width (2**ADDR_WIDTH >= DATA_DEPTH).
REQ-004 SHALL have parameter RO_LIMIT, default 10, words [0, RO_LIMIT-1] are read-only.
REQ-005 SHALL have parameter READ_LATENCY, default 2, REN-to-RDONE cycles (1..4).
REQ-006 SHALL have port clk, input, 1, the single clock, all logic on its rising edge.
REQ-007 SHALL have port resetn, input, 1, reset, asynchronous assert, active-low.
REQ-008 SHALL have port WEN, input, 1, write request for one cycle.
REQ-009 SHALL have port AWADDR, input, ADDR_WIDTH, write word address.
REQ-010 SHALL have port WSTRB, input, DATA_WIDTH/8, byte-lane enables.
REQ-011 SHALL have port WDATA, input, DATA_WIDTH, write data.
REQ-012 SHALL have port WRESP, output, 2, write response.
REQ-013 SHALL have port WDONE, output, 1, one-cycle write-complete pulse.
REQ-014 SHALL have port REN, input, 1, read request for one cycle.
REQ-015 SHALL have port ARADDR, input, ADDR_WIDTH, read word address.
REQ-016 SHALL have port RDATA, output, DATA_WIDTH, read data.
REQ-017 SHALL have port RRESP, output, 2, read response.
REQ-018 SHALL have port RDONE, output, 1, one-cycle read-complete pulse.
REQ-019 SHALL have port ERR_CNT, output, 8, saturating count of non-OKAY responses.

Function
REQ-020 Response codes SHALL be OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
REQ-021 Write decode SHALL be: AWADDR >= DATA_DEPTH -> DECERR; AWADDR < RO_LIMIT -> SLVERR; else OKAY.
REQ-022 On WEN, WDONE SHALL pulse for exactly one cycle, on the cycle after WEN, with WRESP valid in that same cycle; WRESP holds until the next write.
REQ-023 An OKAY write SHALL update only the byte lanes whose WSTRB bit is set; SLVERR/DECERR writes SHALL leave memory unchanged.
REQ-024 A WSTRB of all zeros on a valid address SHALL return OKAY and change nothing.
REQ-025 Read decode SHALL be: ARADDR >= DATA_DEPTH -> DECERR with RDATA=0; else OKAY with the stored word.
REQ-026 Reads SHALL be fully pipelined: one REN per cycle is accepted, each yields RDONE plus RDATA/RRESP exactly READ_LATENCY cycles later, in order.
REQ-027 RDATA/RRESP SHALL hold their last values between RDONE pulses.
REQ-028 A simultaneous read and write to the same address SHALL return the pre-write data (read-first).
REQ-029 A read issued in a later cycle than the write SHALL return the written data.
REQ-030 ERR_CNT SHALL increment by the number of non-OKAY responses (0..2) emitted in a cycle and saturate at 255.
REQ-031 Words 0..RO_LIMIT-1 SHALL power up holding value RO_LIMIT-i; they are not written by reset or by any write.

Reset
REQ-032 On resetn low, outputs SHALL be set asynchronously to: WDONE=0, RDONE=0, RDATA=0, WRESP=DECERR, RRESP=DECERR, ERR_CNT=0.
REQ-033 Reset SHALL flush in-flight reads, with no RDONE for them after release.
REQ-034 Reset SHALL NOT alter memory array contents.
REQ-035 The first request SHALL be accepted on the first rising edge with resetn high.

Structure
REQ-036 Response constants and the response typedef SHALL live in package axil_mem_pkg.
REQ-037 The read delay line (valid/resp/data shift stages) SHALL be sub-module axil_mem_rdpipe, parametrised by DATA_WIDTH and READ_LATENCY.
REQ-038 The array SHALL be a single-write, single-read port inferable RAM with no reset on the array.

Verification
REQ-039 Write AWADDR=20, WDATA=0xDEADBEEF, WSTRB=4'b0101 over 0 -> next cycle WDONE=1, WRESP=00; later read returns 0x00AD00EF.
REQ-040 Write AWADDR=3 -> WRESP=10, WDONE=1, mem[3] still 7; write AWADDR=70 -> WRESP=11; ERR_CNT=2.
REQ-041 REN on 4 consecutive cycles to addrs 0,1,2,3 with READ_LATENCY=2 -> RDONE high on cycles +2..+5 with RDATA 10,9,8,7.
REQ-042 Same-cycle WEN+REN to addr 30 (old 0x11, new 0x22) -> read returns 0x11; the next read returns 0x22.
REQ-043 resetn low while 2 reads are in flight -> no RDONE after release, outputs at reset values, mem[20] unchanged.
REQ-044 Issue 300 DECERR reads -> ERR_CNT stops at 255.
